pipeline_sequencer: RTL and testbench
=====================================

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 Parameter CNT_W, default 16, width of the stall and flush statistics counters.
REQ-002 CLK  input  1  system clock; all state updates occur on the rising edge.
REQ-003 nRST  input  1  asynchronous, active-low reset.
REQ-004 ihit  input  1  instruction memory returned the fetch this cycle.
REQ-005 dhit  input  1  data memory completed the EX/MEM access this cycle.
REQ-006 exmem_dmem  input  1  EX/MEM holds a load or store (dMemRead | dMemWrite).
REQ-007 idex_load  input  1  ID/EX holds a load (dMemRead).
REQ-008 idex_wsel  input  5  destination register of the ID/EX instruction.
REQ-009 ifid_rs, ifid_rt  input  5 each  source registers of the IF/ID instruction.
REQ-010 exmem_redirect  input  1  EX/MEM has a taken branch, jump or jr.
REQ-011 memwb_halt  input  1  MEM/WB holds a halt instruction.
REQ-012 pc_en  output  1  PC may update.
REQ-013 ifid_en, idex_en, exmem_en, memwb_en  output  1 each  pipeline register load enables.
REQ-014 ifid_flush, idex_flush, exmem_flush  output  1 each  load a bubble (all-zero) into that register instead of its input.
REQ-015 halted  output  1  sticky halt indication.
REQ-016 stall_cnt, flush_cnt  output  CNT_W each  saturating statistics counters.

Function
REQ-017 FSM states: RUN, MEMWAIT, DRAIN, HALTED; state registered, all enable/flush outputs combinational from state and inputs.
REQ-018 dwait = exmem_dmem & ~dhit; lu_hazard = idex_load & (idex_wsel != 0) & (idex_wsel == ifid_rs | idex_wsel == ifid_rt).
REQ-019 RUN, priority highest first: memwb_halt -> DRAIN; dwait -> MEMWAIT; else remain RUN.
REQ-020 RUN with dwait: all enables 0, pc_en 0, no flushes (full freeze).
REQ-021 RUN with exmem_redirect and ~dwait: all enables 1, pc_en 1, ifid_flush=1, idex_flush=1, exmem_flush=1; redirect overrides lu_hazard.
REQ-022 RUN with lu_hazard, no redirect, ~dwait: pc_en 0, ifid_en 0, idex_en 1 with idex_flush 1, exmem_en 1, memwb_en 1 (exactly one bubble).
REQ-023 RUN with ~ihit and no other event: pc_en 0, ifid_en 1 with ifid_flush 1, downstream enables 1.
REQ-024 RUN otherwise: pc_en and all enables equal 1 only when ihit=1.
REQ-025 MEMWAIT: full freeze while ~dhit; on dhit, outputs as RUN for that cycle and next state RUN (or DRAIN if memwb_halt).
REQ-026 DRAIN: pc_en 0, ifid_en 0, idex_flush 1, exmem_flush 1, memwb_en 1 for exactly one cycle, then HALTED.
REQ-027 HALTED: all enables and pc_en 0, halted=1; leaves only on reset.
REQ-028 stall_cnt increments by 1 each cycle pc_en=0 while not HALTED; flush_cnt increments by 1 each cycle any flush output is 1; both saturate at 2^CNT_W-1.
REQ-029 Simultaneous memwb_halt and dwait: halt wins; DRAIN entered, outstanding access abandoned.
REQ-030 Simultaneous redirect and ~ihit: redirect outputs per REQ-021 take effect, ifid bubble still inserted.

Reset
REQ-031 nRST low asynchronously forces state RUN, halted 0, stall_cnt 0, flush_cnt 0.
REQ-032 Reset asserted mid-MEMWAIT or mid-DRAIN returns to RUN with counters cleared, no residual freeze after release.

Structure
REQ-033 seq_state_t enum and a packed struct grouping the enable/flush outputs belong in pipeline_types_pkg.
REQ-034 Combinational hazard detection (dwait, lu_hazard) lives in one sub-module named hazard_detect; FSM and counters stay in pipeline_sequencer.

Verification
REQ-035 Load to r5 in ID/EX, IF/ID rs=5, ihit=1 -> one cycle pc_en=0, idex_flush=1, next cycle pc_en=1, stall_cnt=1.
REQ-036 exmem_dmem=1, dhit low 3 cycles then high -> 3 freeze cycles in MEMWAIT, 4th cycle all enables 1, stall_cnt=3.
REQ-037 exmem_redirect=1 with lu_hazard=1 -> ifid/idex/exmem flush=1, pc_en=1, flush_cnt=1, no stall.
REQ-038 memwb_halt=1 with dwait=1 -> DRAIN one cycle, then HALTED, halted=1, pc_en=0 held for 10 cycles.
REQ-039 CNT_W=4, continuous dwait 20 cycles -> stall_cnt saturates at 15.
REQ-040 nRST pulsed low during MEMWAIT -> state RUN, counters 0 immediately, pc_en follows ihit after release.

Source files
------------

// File: rtl/pipeline_types_pkg.sv
// Shared sequencer types: FSM state encoding, grouped enable/flush controls,
// and the per-cycle RUN control decode used by both RUN and MEMWAIT.
package pipeline_types_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_FREEZE = 8'b0000_0000;
  localparam pipe_ctl_t CTL_GO     = 8'b1111_1000;
  // Drain: hold fetch, push bubbles into ID/EX and EX/MEM, let MEM/WB retire.
  localparam pipe_ctl_t CTL_DRAIN  = 8'b0011_1011;

  function automatic pipe_ctl_t run_ctl(input logic dwait, input logic redirect,
                                        input logic lu_hazard, input logic ihit);
    pipe_ctl_t c;
    c = CTL_GO;
    if (dwait) begin
      c = CTL_FREEZE;
    end else if (redirect) begin
      // The IF/ID bubble also covers a missing fetch, so ihit is irrelevant here.
      c.ifid_flush  = 1'b1;
      c.idex_flush  = 1'b1;
      c.exmem_flush = 1'b1;
    end else if (lu_hazard) begin
      c.pc_en      = 1'b0;
      c.ifid_en    = 1'b0;
      c.idex_flush = 1'b1;
    end else if (!ihit) begin
      c.pc_en      = 1'b0;
      c.ifid_flush = 1'b1;
    end
    return c;
  endfunction

  function automatic logic any_flush(input pipe_ctl_t c);
    return c.ifid_flush | c.idex_flush | c.exmem_flush;
  endfunction

endpackage

// File: rtl/pipeline_sequencer_hazard_detect.sv
// Combinational hazard detection: outstanding data access and load-use on IF/ID sources.
// Zero latency, no state, no backpressure of its own.
module hazard_detect
  import pipeline_types_pkg::*;
(
  input  logic       i_exmem_dmem,
  input  logic       i_dhit,
  input  logic       i_idex_load,
  input  logic [4:0] i_idex_wsel,
  input  logic [4:0] i_ifid_rs,
  input  logic [4:0] i_ifid_rt,
  output logic       o_dwait,
  output logic       o_lu_hazard
);

  logic w_src_match;

  assign o_dwait     = i_exmem_dmem & ~i_dhit;
  assign w_src_match = (i_idex_wsel == i_ifid_rs) | (i_idex_wsel == i_ifid_rt);
  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign o_lu_hazard = i_idex_load & (i_idex_wsel != 5'd0) & w_src_match;

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline stall/flush sequencer: registered FSM, combinational enables/flushes, saturating stats.
// Enables respond in the same cycle as their inputs; a data miss freezes every stage.
module pipeline_sequencer
  import pipeline_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_dmem,
  input  logic             idex_load,
  input  logic [4:0]       idex_wsel,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             exmem_redirect,
  input  logic             memwb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  seq_state_t       r_state;
  seq_state_t       w_next;
  pipe_ctl_t        w_ctl;
  logic             w_dwait;
  logic             w_lu_hazard;
  logic             w_stall_inc;
  logic             w_flush_inc;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  hazard_detect u_hazard_detect (
    .i_exmem_dmem (exmem_dmem),
    .i_dhit       (dhit),
    .i_idex_load  (idex_load),
    .i_idex_wsel  (idex_wsel),
    .i_ifid_rs    (ifid_rs),
    .i_ifid_rt    (ifid_rt),
    .o_dwait      (w_dwait),
    .o_lu_hazard  (w_lu_hazard)
  );

  always_comb begin
    w_ctl  = CTL_FREEZE;
    w_next = r_state;
    case (r_state)
      RUN: begin
        w_ctl = run_ctl(w_dwait, exmem_redirect, w_lu_hazard, ihit);
        // Halt outranks a pending access; the access is simply abandoned.
        if (memwb_halt)   w_next = DRAIN;
        else if (w_dwait) w_next = MEMWAIT;
      end
      MEMWAIT: begin
        if (dhit) w_ctl = run_ctl(1'b0, exmem_redirect, w_lu_hazard, ihit);
        if (memwb_halt) w_next = DRAIN;
        else if (dhit)  w_next = RUN;
      end
      DRAIN: begin
        w_ctl  = CTL_DRAIN;
        w_next = HALTED;
      end
      HALTED: begin
        w_ctl  = CTL_FREEZE;
        w_next = HALTED;
      end
      default: begin
        w_ctl  = CTL_FREEZE;
        w_next = RUN;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= RUN;
    else       r_state <= w_next;
  end

  assign w_stall_inc = ~w_ctl.pc_en & (r_state != HALTED) & (r_stall_cnt != '1);
  assign w_flush_inc = any_flush(w_ctl) & (r_flush_cnt != '1);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc) r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (w_flush_inc) r_flush_cnt <= r_flush_cnt + CNT_ONE;
    end
  end

  assign pc_en       = w_ctl.pc_en;
  assign ifid_en     = w_ctl.ifid_en;
  assign idex_en     = w_ctl.idex_en;
  assign exmem_en    = w_ctl.exmem_en;
  assign memwb_en    = w_ctl.memwb_en;
  assign ifid_flush  = w_ctl.ifid_flush;
  assign idex_flush  = w_ctl.idex_flush;
  assign exmem_flush = w_ctl.exmem_flush;
  assign halted      = (r_state == HALTED);
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: single-cycle RUN decode table plus multi-cycle sequences.
module tb_pipeline_sequencer;

  logic        CLK;
  logic        nRST;
  logic        ihit, dhit, exmem_dmem, idex_load, exmem_redirect, memwb_halt;
  logic [4:0]  idex_wsel, ifid_rs, ifid_rt;

  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, halted;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
  logic        s_ifid_flush, s_idex_flush, s_exmem_flush, s_halted;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  logic [7:0]  ctl;
  assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush};

  pipeline_sequencer u_dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .exmem_dmem(exmem_dmem),
    .idex_load(idex_load), .idex_wsel(idex_wsel), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .exmem_redirect(exmem_redirect), .memwb_halt(memwb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_sequencer #(.CNT_W(4)) u_dut4 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .exmem_dmem(exmem_dmem),
    .idex_load(idex_load), .idex_wsel(idex_wsel), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .exmem_redirect(exmem_redirect), .memwb_halt(memwb_halt),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exmem_en(s_exmem_en),
    .memwb_en(s_memwb_en), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
    .exmem_flush(s_exmem_flush), .halted(s_halted), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic       ihit, dhit, exmem_dmem, idex_load, redirect;
    logic [4:0] wsel, rs, rt;
    logic [7:0] exp;  // {pc,ifid,idex,exmem,memwb enables, ifid,idex,exmem flushes}
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input string nm, input logic ih, input logic dh, input logic dm,
                              input logic ld, input logic [4:0] ws, input logic [4:0] rs,
                              input logic [4:0] rt, input logic rd, input logic [7:0] ex);
    vec_t v;
    v.name = nm; v.ihit = ih; v.dhit = dh; v.exmem_dmem = dm; v.idex_load = ld;
    v.wsel = ws; v.rs = rs; v.rt = rt; v.redirect = rd; v.exp = ex;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b0; exmem_dmem = 1'b0; idex_load = 1'b0;
    idex_wsel = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    exmem_redirect = 1'b0; memwb_halt = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    nRST = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check("reset_stall", 32'(stall_cnt), 0);
    check("reset_flush", 32'(flush_cnt), 0);
    check("reset_halted", 32'(halted), 0);
    nRST = 1'b1;
  endtask

  initial begin
    int exp_stall;
    int exp_flush;

    vecs[0]  = mk("normal",          1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 8'b1111_1000);
    vecs[1]  = mk("ifetch_miss",     0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 8'b0111_1100);
    vecs[2]  = mk("lu_rs",           1, 0, 0, 1, 5'd5, 5'd5, 5'd1, 0, 8'b0011_1010);
    vecs[3]  = mk("lu_rt",           1, 0, 0, 1, 5'd7, 5'd2, 5'd7, 0, 8'b0011_1010);
    vecs[4]  = mk("load_r0",         1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 8'b1111_1000);
    vecs[5]  = mk("load_nomatch",    1, 0, 0, 1, 5'd5, 5'd3, 5'd4, 0, 8'b1111_1000);
    vecs[6]  = mk("noload_match",    1, 0, 0, 0, 5'd5, 5'd5, 5'd5, 0, 8'b1111_1000);
    vecs[7]  = mk("redirect_lu",     1, 0, 0, 1, 5'd9, 5'd9, 5'd0, 1, 8'b1111_1111);
    vecs[8]  = mk("redirect_imiss",  0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 8'b1111_1111);
    vecs[9]  = mk("dmem_hit",        1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 8'b1111_1000);
    vecs[10] = mk("lu_and_imiss",    0, 0, 0, 1, 5'd3, 5'd1, 5'd3, 0, 8'b0011_1010);

    nRST = 1'b0;
    idle_inputs();
    do_reset();

    // Single-cycle RUN decode; none of these leave RUN, counters accumulate.
    exp_stall = 0;
    exp_flush = 0;
    for (int i = 0; i < 11; i++) begin
      ihit = vecs[i].ihit; dhit = vecs[i].dhit; exmem_dmem = vecs[i].exmem_dmem;
      idex_load = vecs[i].idex_load; idex_wsel = vecs[i].wsel;
      ifid_rs = vecs[i].rs; ifid_rt = vecs[i].rt; exmem_redirect = vecs[i].redirect;
      #1;
      check({"ctl_", vecs[i].name}, 32'(ctl), 32'(vecs[i].exp));
      if (!vecs[i].exp[7]) exp_stall++;
      if (vecs[i].exp[2:0] != 3'b000) exp_flush++;
      tick();
      check({"stall_", vecs[i].name}, 32'(stall_cnt), exp_stall);
      check({"flush_", vecs[i].name}, 32'(flush_cnt), exp_flush);
    end

    // Load-use: one bubble, then resume.
    do_reset();
    idex_load = 1; idex_wsel = 5'd5; ifid_rs = 5'd5; ifid_rt = 5'd0;
    #1;
    check("lu_pc_en", 32'(pc_en), 0);
    check("lu_idex_flush", 32'(idex_flush), 1);
    tick();
    idex_load = 0;
    #1;
    check("lu_resume_pc_en", 32'(pc_en), 1);
    check("lu_stall_cnt", 32'(stall_cnt), 1);

    // Data miss for three cycles, hit on the fourth.
    do_reset();
    exmem_dmem = 1; dhit = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("dwait_freeze", 32'(ctl), 0);
      tick();
    end
    dhit = 1;
    #1;
    check("dwait_release", 32'(ctl), 32'h0000_00F8);
    check("dwait_stall_cnt", 32'(stall_cnt), 3);
    tick();
    exmem_dmem = 0; dhit = 0;
    #1;
    check("dwait_back_run", 32'(ctl), 32'h0000_00F8);

    // Redirect beats a load-use hazard.
    do_reset();
    exmem_redirect = 1; idex_load = 1; idex_wsel = 5'd4; ifid_rt = 5'd4;
    #1;
    check("redir_ctl", 32'(ctl), 32'h0000_00FF);
    tick();
    exmem_redirect = 0; idex_load = 0;
    #1;
    check("redir_flush_cnt", 32'(flush_cnt), 1);
    check("redir_stall_cnt", 32'(stall_cnt), 0);

    // Halt with an outstanding access: drain once, then stay halted.
    do_reset();
    memwb_halt = 1; exmem_dmem = 1; dhit = 0;
    tick();
    memwb_halt = 0; exmem_dmem = 0;
    #1;
    check("drain_ctl", 32'(ctl), 32'h0000_003B);
    check("drain_halted", 32'(halted), 0);
    tick();
    for (int c = 0; c < 10; c++) begin
      ihit = c[0];
      #1;
      check("halted_ctl", 32'(ctl), 0);
      check("halted_flag", 32'(halted), 1);
      tick();
    end
    check("halted_stall_cnt", 32'(stall_cnt), 2);
    check("halted_flush_cnt", 32'(flush_cnt), 1);

    // Saturation of the 4-bit counter under a long data miss.
    do_reset();
    exmem_dmem = 1; dhit = 0;
    repeat (20) tick();
    check("sat_stall_cnt4", 32'(s_stall_cnt), 15);
    check("sat_stall_cnt16", 32'(stall_cnt), 20);

    // Reset in the middle of MEMWAIT.
    do_reset();
    exmem_dmem = 1; dhit = 0;
    tick();
    tick();
    check("mw_stall_before", 32'(stall_cnt), 2);
    nRST = 0;
    #1;
    check("mw_rst_stall", 32'(stall_cnt), 0);
    check("mw_rst_flush", 32'(flush_cnt), 0);
    check("mw_rst_halted", 32'(halted), 0);
    exmem_dmem = 0; ihit = 1;
    #1;
    check("mw_rst_run_ctl", 32'(ctl), 32'h0000_00F8);
    tick();
    nRST = 1;
    #1;
    check("mw_rel_pc_en_hit", 32'(pc_en), 1);
    ihit = 0;
    #1;
    check("mw_rel_pc_en_miss", 32'(pc_en), 0);
    check("mw_rel_ctl_miss", 32'(ctl), 32'h0000_007C);
    tick();
    check("mw_rel_stall_cnt", 32'(stall_cnt), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
